// File: rtl/div_seq.sv
// div_seq: multi-cycle non-restoring integer divider (signed/unsigned) for DIV.
// One quotient bit per cycle, start/done handshake, divide-by-zero reporting.
// result packs {remainder, quotient} for the HI/LO register pair.
// Optional build macro DIV_EARLY_EXIT_EN: finish straight from PREP when
// |divisor| > |dividend|. The results are the same; only the latency is shorter.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        FIN
    } state_t;

    state_t             state;

    // operands captured on an accepted start
    logic [WIDTH-1:0]   lat_dividend;
    logic [WIDTH-1:0]   lat_divisor;
    logic               lat_signed;

    // working registers: acc is the signed partial remainder (one extra bit)
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   mag_m;
    logic [CNT_W-1:0]   count;
    logic               sign_q;
    logic               sign_r;

    // combinational helpers
    logic [WIDTH-1:0]   mag_dd;
    logic [WIDTH-1:0]   mag_dv;
    logic [WIDTH:0]     acc_shift;
    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   rem_mag;

    // Operand magnitudes, one non-restoring step, and the remainder restore
    always_comb begin
        mag_dd    = lat_dividend;
        mag_dv    = lat_divisor;
        if (lat_signed && lat_dividend[WIDTH-1]) begin
            mag_dd = -lat_dividend;
        end
        if (lat_signed && lat_divisor[WIDTH-1]) begin
            mag_dv = -lat_divisor;
        end
        acc_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
        if (acc[WIDTH]) begin
            acc_step = acc_shift + {1'b0, mag_m};
        end else begin
            acc_step = acc_shift - {1'b0, mag_m};
        end
        // only the low WIDTH bits of the restored remainder are ever used
        if (acc[WIDTH]) begin
            rem_mag = acc[WIDTH-1:0] + mag_m;
        end else begin
            rem_mag = acc[WIDTH-1:0];
        end
    end

    // Control FSM and datapath with registered handshake and result outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            lat_dividend <= '0;
            lat_divisor  <= '0;
            lat_signed   <= 1'b0;
            acc          <= '0;
            quo          <= '0;
            mag_m        <= '0;
            count        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_dividend <= dividend;
                        lat_divisor  <= divisor;
                        lat_signed   <= signed_op;
                        div_by_zero  <= 1'b0;
                        busy         <= 1'b1;
                        state        <= PREP;
                    end else begin
                        state        <= IDLE;
                    end
                end

                PREP: begin
                    sign_q <= lat_signed & (lat_dividend[WIDTH-1] ^ lat_divisor[WIDTH-1]);
                    sign_r <= lat_signed & lat_dividend[WIDTH-1];
                    acc    <= '0;
                    quo    <= mag_dd;
                    mag_m  <= mag_dv;
                    count  <= '0;
                    if (lat_divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= lat_dividend;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag_dv > mag_dd) begin
                        quotient    <= '0;
                        remainder   <= lat_dividend;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
`endif
                    else begin
                        state <= ITER;
                    end
                end

                ITER: begin
                    acc   <= acc_step;
                    quo   <= {quo[WIDTH-2:0], ~acc_step[WIDTH]};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    quotient  <= sign_q ? -quo : quo;
                    remainder <= sign_r ? -rem_mag : rem_mag;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= FIN;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign result = {remainder, quotient};

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq (WIDTH=32).
// Latency is counted in rising edges after the edge that samples start:
// the full path shows done after WIDTH+2 edges (PREP, WIDTH x ITER, FIX);
// the divide-by-zero and early-exit paths show it after the first edge.
module tb_div_seq;

    localparam int W          = 32;
    localparam int LAT_FULL   = W + 2;
    localparam int LAT_SHORT  = 1;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL  = LAT_SHORT;
`else
    localparam int LAT_SMALL  = LAT_FULL;
`endif

    logic             clock = 1'b0;
    logic             clear;
    logic             start;
    logic             signed_op;
    logic [W-1:0]     dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic [2*W-1:0]   result;

    int checks   = 0;
    int failures = 0;

    div_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .result      (result)
    );

    always #5 clock = ~clock;

    // Wait for done, counting edges; busy must stay high until done arrives.
    task automatic wait_done(output logic [W-1:0] q, output logic [W-1:0] r,
                             output logic dbz, output int lat,
                             output logic busy_ok, output logic timed_out);
        q = '0; r = '0; dbz = 1'b0; lat = 0; busy_ok = 1'b1; timed_out = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = i; q = quotient; r = remainder; dbz = div_by_zero;
                if (busy) busy_ok = 1'b0;
                timed_out = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    // Issue one start from idle and wait for its completion.
    task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sop,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dbz, output int lat,
                           output logic busy_ok, output logic timed_out);
        logic b0;
        @(negedge clock);
        dividend = dd; divisor = dv; signed_op = sop; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        b0 = busy;
        wait_done(q, r, dbz, lat, busy_ok, timed_out);
        if (!b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        #12;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/dbz got %b expected 000", {busy, done, div_by_zero});
        end
        checks++;
        if (result !== '0 || quotient !== '0 || remainder !== '0) begin
            failures++;
            $display("FAIL reset_data: result got %h expected 0", result);
        end
        @(negedge clock); clear = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] dd_t [8] = '{32'h00000007, 32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9,
                                   32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [W-1:0] dv_t [8] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                   32'h00000002, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF};
        logic         sg_t [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] eq_t [8] = '{32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000003,
                                   32'h7FFFFFFF, 32'h80000000, 32'h2AAAAAAA, 32'h00000001};
        logic [W-1:0] er_t [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                                   32'h00000001, 32'h00000000, 32'h00000002, 32'h00000000};
        logic [W-1:0] q, r;
        logic         dbz, bok, tmo;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            run_div(dd_t[i], dv_t[i], sg_t[i], q, r, dbz, lat, bok, tmo);
            checks++;
            if (tmo !== 1'b0) begin
                failures++;
                $display("FAIL arith%0d_timeout: no done within bound", i);
            end
            checks++;
            if (q !== eq_t[i]) begin
                failures++;
                $display("FAIL arith%0d_quotient: got %h expected %h", i, q, eq_t[i]);
            end
            checks++;
            if (r !== er_t[i]) begin
                failures++;
                $display("FAIL arith%0d_remainder: got %h expected %h", i, r, er_t[i]);
            end
            checks++;
            if (dbz !== 1'b0) begin
                failures++;
                $display("FAIL arith%0d_dbz: got %b expected 0", i, dbz);
            end
            checks++;
            if (lat != LAT_FULL) begin
                failures++;
                $display("FAIL arith%0d_latency: got %0d expected %0d", i, lat, LAT_FULL);
            end
            checks++;
            if (bok !== 1'b1) begin
                failures++;
                $display("FAIL arith%0d_busy: busy got %b expected 1 while running", i, bok);
            end
            checks++;
            if (result !== {er_t[i], eq_t[i]}) begin
                failures++;
                $display("FAIL arith%0d_result: got %h expected %h", i, result, {er_t[i], eq_t[i]});
            end
            @(posedge clock); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL arith%0d_done_pulse: done got %b expected 0 after one cycle", i, done);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [W-1:0] q, r;
        logic         dbz, bok, tmo;
        int           lat;
        run_div(32'd25, 32'd0, 1'b1, q, r, dbz, lat, bok, tmo);
        checks++;
        if (tmo !== 1'b0 || lat != LAT_SHORT) begin
            failures++;
            $display("FAIL dbz_latency: got %0d (timeout %b) expected %0d", lat, tmo, LAT_SHORT);
        end
        checks++;
        if (dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_flag: got %b expected 1", dbz);
        end
        checks++;
        if (q !== 32'hFFFFFFFF || r !== 32'h00000019) begin
            failures++;
            $display("FAIL dbz_values: got q=%h r=%h expected q=ffffffff r=00000019", q, r);
        end
        // back-to-back 9/3 accepted in the FIN cycle clears the flag
        dividend = 32'd9; divisor = 32'd3; signed_op = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if ({done, busy, div_by_zero} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_accept: done/busy/dbz got %b expected 010", {done, busy, div_by_zero});
        end
        wait_done(q, r, dbz, lat, bok, tmo);
        checks++;
        if (tmo !== 1'b0 || lat != LAT_FULL) begin
            failures++;
            $display("FAIL b2b_latency: got %0d (timeout %b) expected %0d", lat, tmo, LAT_FULL);
        end
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL b2b_values: got q=%h r=%h dbz=%b expected q=3 r=0 dbz=0", q, r, dbz);
        end
        // negative dividend is reported unmodified as the remainder
        run_div(32'hFFFFFFF9, 32'd0, 1'b1, q, r, dbz, lat, bok, tmo);
        checks++;
        if (q !== 32'hFFFFFFFF || r !== 32'hFFFFFFF9 || dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_neg: got q=%h r=%h dbz=%b expected q=ffffffff r=fffffff9 dbz=1", q, r, dbz);
        end
    endtask

    task automatic test_clear_mid_op();
        logic [W-1:0] q, r;
        logic         dbz, bok, tmo;
        int           lat;
        run_div(32'd9, 32'd3, 1'b0, q, r, dbz, lat, bok, tmo);
        @(negedge clock);
        dividend = 32'd1000; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || quotient !== 32'd3) begin
            failures++;
            $display("FAIL clear_pre: busy=%b quotient=%h expected busy=1 quotient=3", busy, quotient);
        end
        clear = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || result !== '0) begin
            failures++;
            $display("FAIL clear_async: flags=%b result=%h expected 000 and 0", {busy, done, div_by_zero}, result);
        end
        @(posedge clock); #1;
        checks++;
        if ({busy, done} !== 2'b00 || result !== '0) begin
            failures++;
            $display("FAIL clear_held: busy/done=%b result=%h expected 00 and 0", {busy, done}, result);
        end
        @(negedge clock); clear = 1'b0;
        run_div(32'd100, 32'd7, 1'b0, q, r, dbz, lat, bok, tmo);
        checks++;
        if (tmo !== 1'b0 || lat != LAT_FULL || q !== 32'd14 || r !== 32'd2) begin
            failures++;
            $display("FAIL clear_fresh: got q=%h r=%h lat=%0d expected q=e r=2 lat=%0d", q, r, lat, LAT_FULL);
        end
    endtask

    task automatic test_busy_start_ignored();
        int           n_done = 0;
        int           lat = 0;
        logic [W-1:0] q = '0;
        logic [W-1:0] r = '0;
        @(negedge clock);
        dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 3 || i == 10 || i == 20) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_op = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            if (done) begin
                n_done++; lat = i; q = quotient; r = remainder;
            end
        end
        start = 1'b0;
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL ignore_count: done pulses got %0d expected 1", n_done);
        end
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || lat != LAT_FULL) begin
            failures++;
            $display("FAIL ignore_values: got q=%h r=%h lat=%0d expected q=e r=2 lat=%0d", q, r, lat, LAT_FULL);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_small_quotient();
        logic [W-1:0] q, r;
        logic         dbz, bok, tmo;
        int           lat;
        run_div(32'd3, 32'd10, 1'b0, q, r, dbz, lat, bok, tmo);
        checks++;
        if (tmo !== 1'b0 || lat != LAT_SMALL) begin
            failures++;
            $display("FAIL small_latency: got %0d (timeout %b) expected %0d", lat, tmo, LAT_SMALL);
        end
        checks++;
        if (q !== 32'd0 || r !== 32'd3 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL small_unsigned: got q=%h r=%h dbz=%b expected q=0 r=3 dbz=0", q, r, dbz);
        end
        run_div(32'hFFFFFFFD, 32'd10, 1'b1, q, r, dbz, lat, bok, tmo);
        checks++;
        if (q !== 32'd0 || r !== 32'hFFFFFFFD || lat != LAT_SMALL) begin
            failures++;
            $display("FAIL small_negdd: got q=%h r=%h lat=%0d expected q=0 r=fffffffd lat=%0d", q, r, lat, LAT_SMALL);
        end
        run_div(32'd5, 32'hFFFFFFF9, 1'b1, q, r, dbz, lat, bok, tmo);
        checks++;
        if (q !== 32'd0 || r !== 32'd5 || lat != LAT_SMALL) begin
            failures++;
            $display("FAIL small_negdv: got q=%h r=%h lat=%0d expected q=0 r=5 lat=%0d", q, r, lat, LAT_SMALL);
        end
        // |divisor| < |dividend| in signed mode always takes the full path
        run_div(32'hFFFFFFF6, 32'd3, 1'b1, q, r, dbz, lat, bok, tmo);
        checks++;
        if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF || lat != LAT_FULL) begin
            failures++;
            $display("FAIL small_full: got q=%h r=%h lat=%0d expected q=fffffffd r=ffffffff lat=%0d", q, r, lat, LAT_FULL);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_by_zero();
        test_clear_mid_op();
        test_busy_start_ignored();
        test_small_quotient();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
